// File: rtl/mips_fetch_unit_if.sv
// Instruction block-RAM bus between the fetch unit and its memory.
//   imem_addr : word address driven by the fetch unit
//   imem_en   : read enable driven by the fetch unit
//   imem_dout : read data driven by the RAM, valid one cycle after an enabled read
interface mips_fetch_unit_if #(parameter int ADDR_WIDTH = 10);
  logic [ADDR_WIDTH-1:0] imem_addr;
  logic                  imem_en;
  logic [31:0]           imem_dout;

  modport master (output imem_addr, output imem_en, input imem_dout);
  modport slave  (input imem_addr, input imem_en, output imem_dout);
endinterface

// File: rtl/mips_fetch_unit.sv
// MIPS instruction-fetch stage. Holds the PC, reads the instruction RAM
// (1-cycle latency), latches the IR and steps the PC sequentially or to the
// branch target once the control unit's registered Branch is valid.
// Ports:
//   CLK, Reset (async, active low)
//   Stall       : holds the unit in S_EXEC
//   Branch/Zero : branch control and ALU zero flag, sampled only in S_EXEC
//   imem        : instruction RAM bus (master side)
//   Instruction : IR; Opcode = IR[31:26]
//   PC, PCPlus4 : current byte address and PC+4
//   InstrValid  : one-cycle pulse while the freshly loaded IR is in S_DECODE
module mips_fetch_unit #(
  parameter int          ADDR_WIDTH = 10,
  parameter logic [31:0] RESET_PC   = 32'h0000_0000
) (
  input  logic                     CLK,
  input  logic                     Reset,
  input  logic                     Stall,
  input  logic                     Branch,
  input  logic                     Zero,
  mips_fetch_unit_if.master        imem,
  output logic [31:0]              Instruction,
  output logic [5:0]               Opcode,
  output logic [31:0]              PC,
  output logic [31:0]              PCPlus4,
  output logic                     InstrValid
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_WAIT   = 3'd2,
    S_DECODE = 3'd3,
    S_EXEC   = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] ir_q, ir_d;
  logic        vld_q, vld_d;
  logic [31:0] br_off;

  assign PCPlus4        = pc_q + 32'd4;
  // sign_extend(imm16) << 2
  assign br_off         = {{14{ir_q[15]}}, ir_q[15:0], 2'b00};
  // upper PC bits are dropped, so the RAM aliases across the address space
  assign imem.imem_addr = pc_q[ADDR_WIDTH+1:2];

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    ir_d         = ir_q;
    vld_d        = 1'b0;
    imem.imem_en = 1'b0;
    case (state_q)
      S_IDLE:   state_d = S_FETCH;
      S_FETCH: begin
        imem.imem_en = 1'b1;
        state_d      = S_WAIT;
      end
      S_WAIT: begin
        // RAM data is valid now: capture it and flag it for the DECODE cycle
        ir_d    = imem.imem_dout;
        vld_d   = 1'b1;
        state_d = S_DECODE;
      end
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        if (!Stall) begin
          pc_d    = (Branch && Zero) ? PCPlus4 + br_off : PCPlus4;
          state_d = S_FETCH;
        end
      end
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge Reset) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      pc_q    <= RESET_PC;
      ir_q    <= 32'h0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      ir_q    <= ir_d;
      vld_q   <= vld_d;
    end
  end

  assign PC          = pc_q;
  assign Instruction = ir_q;
  assign Opcode      = ir_q[31:26];
  assign InstrValid  = vld_q;

endmodule

// File: tb/tb_mips_fetch_unit.sv
module tb_mips_fetch_unit;
  logic        CLK = 1'b0;
  logic        Reset = 1'b1, Stall = 1'b0, Branch = 1'b0, Zero = 1'b0;
  logic [31:0] Instruction, PC, PCPlus4;
  logic [5:0]  Opcode;
  logic        InstrValid;

  logic        rstw_n = 1'b1;
  logic        stw = 1'b0, brw = 1'b0, zw = 1'b0;
  logic [31:0] ir_w, pc_w, pc4_w;
  logic [5:0]  op_w;
  logic        vld_w;

  logic [31:0] mem [1024];
  logic [31:0] exp_pc;
  int          tests = 0, fails = 0;

  always #5 CLK = ~CLK;

  mips_fetch_unit_if #(.ADDR_WIDTH(10)) imem_if ();
  mips_fetch_unit_if #(.ADDR_WIDTH(10)) imem_w ();

  mips_fetch_unit #(.ADDR_WIDTH(10), .RESET_PC(32'h0)) dut (
    .CLK(CLK), .Reset(Reset), .Stall(Stall), .Branch(Branch), .Zero(Zero),
    .imem(imem_if), .Instruction(Instruction), .Opcode(Opcode),
    .PC(PC), .PCPlus4(PCPlus4), .InstrValid(InstrValid));

  mips_fetch_unit #(.ADDR_WIDTH(10), .RESET_PC(32'hFFFF_FFFC)) dut_w (
    .CLK(CLK), .Reset(rstw_n), .Stall(stw), .Branch(brw), .Zero(zw),
    .imem(imem_w), .Instruction(ir_w), .Opcode(op_w),
    .PC(pc_w), .PCPlus4(pc4_w), .InstrValid(vld_w));

  // synchronous block RAM models, 1-cycle read latency
  always @(posedge CLK) if (imem_if.imem_en) imem_if.imem_dout <= mem[imem_if.imem_addr];
  always @(posedge CLK) if (imem_w.imem_en)  imem_w.imem_dout  <= mem[imem_w.imem_addr];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One instruction: starts at a negedge just before FETCH, ends on the last
  // EXEC negedge. Reference: PC' = PC + 4 + (taken ? 4*imm16 : 0).
  task automatic run_instr(input bit br, input bit z, input int nst);
    int          cyc = 0, en_cnt = 0, en_cyc = 0, off;
    logic [9:0]  en_addr = '0;
    logic [31:0] w;
    do begin
      @(negedge CLK);
      cyc++;
      if (imem_if.imem_en === 1'b1) begin
        en_cnt++; en_cyc = cyc; en_addr = imem_if.imem_addr;
      end
    end while (InstrValid !== 1'b1 && cyc < 20);
    w = mem[exp_pc[11:2]];
    chk("valid_latency", cyc, 3);
    chk("fetch_count", en_cnt, 1);
    chk("fetch_cycle", en_cyc, 1);
    chk("imem_addr", {22'h0, en_addr}, {22'h0, exp_pc[11:2]});
    chk("pc", PC, exp_pc);
    chk("pcplus4", PCPlus4, exp_pc + 32'd4);
    chk("instruction", Instruction, w);
    chk("opcode", {26'h0, Opcode}, {26'h0, w[31:26]});
    Branch = br; Zero = z; Stall = (nst > 0);
    for (int i = 0; i <= nst; i++) begin
      @(negedge CLK);
      if (i == nst) Stall = 1'b0;
      chk("exec_pc", PC, exp_pc);
      chk("exec_en", {31'h0, imem_if.imem_en}, 32'h0);
      chk("exec_ir", Instruction, w);
      chk("exec_valid", {31'h0, InstrValid}, 32'h0);
    end
    Stall = 1'b0;
    off = $signed(w[15:0]);
    exp_pc = exp_pc + 32'd4 + ((br && z) ? 32'(off * 4) : 32'd0);
  endtask

  initial begin
    logic [31:0] en_a [2];
    logic [31:0] v_pc [2];
    logic [31:0] v_ir;
    int ne, nv;

    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    mem[0] = 32'h8C01_0004;
    mem[1] = 32'h2002_0011;
    mem[2] = 32'h1000_0003;
    mem[3] = 32'hAC03_0008;
    mem[4] = 32'h1000_FFFE;

    #1 Reset = 1'b0; rstw_n = 1'b0;
    repeat (3) begin
      @(negedge CLK);
      chk("rst_pc", PC, 32'h0);
      chk("rst_ir", Instruction, 32'h0);
      chk("rst_opcode", {26'h0, Opcode}, 32'h0);
      chk("rst_valid", {31'h0, InstrValid}, 32'h0);
      chk("rst_en", {31'h0, imem_if.imem_en}, 32'h0);
    end
    Reset = 1'b1;
    exp_pc = 32'h0;

    run_instr(0, 0, 0);   // 0x0  lw
    run_instr(0, 1, 3);   // 0x4  stalled 3 cycles
    run_instr(1, 0, 0);   // 0x8  beq not taken -> 0xC
    run_instr(0, 0, 0);   // 0xC
    run_instr(1, 1, 0);   // 0x10 beq -2 taken -> 0xC
    chk("neg_branch_target", exp_pc, 32'h0000_000C);

    // reset asserted between edges while in S_WAIT at PC=0xC
    @(negedge CLK);
    chk("midrst_fetch_en", {31'h0, imem_if.imem_en}, 32'h1);
    chk("midrst_fetch_pc", PC, 32'h0000_000C);
    @(negedge CLK);
    #2 Reset = 1'b0;
    #1;
    chk("midrst_pc", PC, 32'h0);
    chk("midrst_ir", Instruction, 32'h0);
    chk("midrst_en", {31'h0, imem_if.imem_en}, 32'h0);
    repeat (3) begin
      @(negedge CLK);
      chk("midrst_valid", {31'h0, InstrValid}, 32'h0);
    end
    Reset = 1'b1;
    exp_pc = 32'h0;

    run_instr(0, 0, 0);
    run_instr(0, 0, 0);
    run_instr(1, 1, 1);   // 0x8 beq +3 taken -> 0x18
    chk("pos_branch_target", exp_pc, 32'h0000_0018);

    for (int n = 0; n < 40; n++)
      run_instr(1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));

    // wrap instance: RESET_PC=0xFFFFFFFC, free-running sequential path
    @(negedge CLK);
    rstw_n = 1'b1;
    ne = 0; nv = 0; v_ir = '0;
    en_a[0] = 'x; en_a[1] = 'x; v_pc[0] = 'x; v_pc[1] = 'x;
    for (int c = 0; c < 40 && (ne < 2 || nv < 2); c++) begin
      @(negedge CLK);
      if (imem_w.imem_en === 1'b1 && ne < 2) begin en_a[ne] = {22'h0, imem_w.imem_addr}; ne++; end
      if (vld_w === 1'b1 && nv < 2) begin
        if (nv == 0) v_ir = ir_w;
        v_pc[nv] = pc_w; nv++;
      end
    end
    chk("wrap_addr0", en_a[0], 32'h0000_03FF);
    chk("wrap_addr1", en_a[1], 32'h0000_0000);
    chk("wrap_pc0", v_pc[0], 32'hFFFF_FFFC);
    chk("wrap_pc1", v_pc[1], 32'h0000_0000);
    chk("wrap_ir0", v_ir, mem[1023]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
